sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8: word-array depth is 2**ADDR_BITS 16-bit words.
REQ-002 Parameter READ_LATENCY, default 1, legal range 1..3: number of cycles from read acceptance to first data drive.
REQ-003 The block SHALL have one clock, and reset SHALL be asynchronous and active-low; ports are named Clk and Reset.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 Reset  in  1  asynchronous active-low reset.
REQ-006 CE, OE, WE  in  1 each  active-low chip enable, output enable and write enable from the CPU.
REQ-007 UB, LB  in  1 each  active-low upper-byte and lower-byte lane enables.
REQ-008 ADDR  in  20  word address.
REQ-009 Data  inout  16  shared data bus; the block drives it only as specified below.
REQ-010 Init_WE, Init_Addr[ADDR_BITS-1:0], Init_Data[16]  in  bench/boot preload port; writes a full word when Init_WE=1 and the FSM is IDLE.
REQ-011 Rd_Valid  out  1  high while the block drives Data.
REQ-012 Err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-013 FSM states SHALL be IDLE, RD_WAIT, RD_DRIVE and WR_DONE, with CE, OE, WE, UB, LB and ADDR sampled on the rising edge of Clk.
REQ-014 IDLE transitions: CE=0 & WE=0 -> commit write, go to WR_DONE; CE=0 & OE=0 & WE=1 -> latch ADDR, load latency counter with READ_LATENCY-1, go to RD_WAIT; otherwise stay.
REQ-015 RD_WAIT transitions: counter>0 -> decrement; counter=0 -> register the read word and go to RD_DRIVE.
REQ-016 RD_DRIVE: Data = registered word and Rd_Valid=1, combinationally gated by CE=0 & OE=0 & WE=1; otherwise Data is high-Z and Rd_Valid=0.
REQ-017 RD_DRIVE exit: CE=1 or OE=1 -> IDLE; ADDR differing from the latched address -> re-latch and go to RD_WAIT; WE=0 -> IDLE, with the write accepted from IDLE on the next edge.
REQ-018 Read latency: first cycle with Data valid is READ_LATENCY+1 edges after the request is sampled.
REQ-019 Write: exactly one commit per access; UB=0 updates bits [15:8], LB=0 updates bits [7:0], and UB=LB=1 leaves the word unchanged.
REQ-020 WR_DONE SHALL hold with no further commits until CE=1 or WE=1, then return to IDLE.
REQ-021 Read byte lanes: a disabled lane SHALL read as 8'h00.
REQ-022 Simultaneous WE=0 & OE=0: write has priority, and Data SHALL never be driven while WE=0.
REQ-023 Out of range (ADDR[19:ADDR_BITS] nonzero and not a mapped I/O address): reads return 16'h0000, writes are ignored, and Err pulses for one cycle at acceptance.
REQ-024 An Init_WE write arriving outside IDLE SHALL be dropped.

Reset
REQ-025 Reset=0 SHALL immediately force state IDLE, Data high-Z, Rd_Valid=0, Err=0, latency counter 0 and the I/O register 0.
REQ-026 Reset SHALL NOT clear array contents; a reset mid-read releases Data asynchronously, and a reset mid-write leaves an already committed word intact.

Configuration
REQ-027 Macro SRAM_RESPONDER_IO_EN defined: add ports Switches in 16 and Hex_Out out 16 (reset 0); ADDR=20'h0FFFF reads Switches with READ_LATENCY timing and lane masking, and writes update Hex_Out per lane.
REQ-028 Macro SRAM_RESPONDER_IO_EN undefined: no extra ports, and 20'h0FFFF is treated as out of range.

Verification
REQ-029 Preload word[0x12]=16'hBEEF, READ_LATENCY=1, CE=OE=0, WE=1, ADDR=0x12 -> Data=16'hBEEF and Rd_Valid=1 from the 2nd edge, and high-Z one cycle after OE=1.
REQ-030 Write 16'hA5C3 to 0x05 with UB=1, LB=0 over a word holding 16'h1111, WE held low for 3 cycles -> word becomes 16'h11C3 with one commit only; next read returns 16'h11C3.
REQ-031 READ_LATENCY=3, ADDR changed 0x01->0x02 while in RD_DRIVE -> Data high-Z for 3 cycles, then word[0x02].
REQ-032 WE=0 and OE=0 both asserted, ADDR=0x07, Data=16'h0042 -> word[0x07]=16'h0042 and Data never driven by the block.
REQ-033 ADDR=20'h10000 read -> Err one-cycle pulse and Data=16'h0000; with SRAM_RESPONDER_IO_EN, Switches=16'h00F3 at 0x0FFFF read -> 16'h00F3, and a write of 16'h1234 sets Hex_Out=16'h1234.
REQ-034 Reset asserted in RD_DRIVE -> Data high-Z and Rd_Valid=0 before the next edge; after release, word contents are unchanged.

Source files
------------

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_responder
//  Description : Clocked responder that models an asynchronous 16-bit SRAM
//                behind a CPU-style bus (CE/OE/WE/UB/LB, shared Data bus).
//                Reads have READ_LATENCY cycles of wait before the word is
//                driven; writes commit once per access with byte-lane masks.
//                Optional memory-mapped I/O at 20'h0FFFF is enabled by the
//                macro SRAM_RESPONDER_IO_EN (Switches in, Hex_Out out).
//  Revision    : 1.0  initial release
// ============================================================================
module sram_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CE,
    input  logic                 OE,
    input  logic                 WE,
    input  logic                 UB,
    input  logic                 LB,
    input  logic [19:0]          ADDR,
    inout  wire  [15:0]          Data,
    input  logic                 Init_WE,
    input  logic [ADDR_BITS-1:0] Init_Addr,
    input  logic [15:0]          Init_Data,
`ifdef SRAM_RESPONDER_IO_EN
    input  logic [15:0]          Switches,
    output logic [15:0]          Hex_Out,
`endif
    output logic                 Rd_Valid,
    output logic                 Err
);

    localparam int          c_DEPTH    = 2 ** ADDR_BITS;
    localparam logic [1:0]  c_LAT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [19:0] c_IO_ADDR  = 20'h0FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WR_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_lat_cnt;
    logic [19:0] r_addr;
    logic [15:0] r_rd_data;
    logic        r_err;
    logic [15:0] r_mem [c_DEPTH];

    logic        w_rd_accept;
    logic        w_capture;
    logic        w_cnt_dec;
    logic        w_cpu_wr;
    logic        w_mem_wr;
    logic        w_init_wr;
    logic        w_drive;
    logic        w_req_map;
    logic        w_req_io;
    logic        w_req_oor;
    logic        w_lat_map;
    logic        w_lat_io;
    logic        w_lat_oor;
    logic [15:0] w_io_src;
    logic [15:0] w_rd_src;
    logic [15:0] w_rd_word;

    // Address decode for the live request and for the latched read address.
    // Without the I/O option the I/O address is simply another hole in the map.
    assign w_req_map = (ADDR == c_IO_ADDR);
    assign w_lat_map = (r_addr == c_IO_ADDR);
`ifdef SRAM_RESPONDER_IO_EN
    assign w_req_io  = w_req_map;
    assign w_lat_io  = w_lat_map;
    assign w_req_oor = ((ADDR >> ADDR_BITS) != 20'd0) && !w_req_map;
    assign w_lat_oor = ((r_addr >> ADDR_BITS) != 20'd0) && !w_lat_map;
    assign w_io_src  = Switches;
`else
    assign w_req_io  = 1'b0;
    assign w_lat_io  = 1'b0;
    assign w_req_oor = ((ADDR >> ADDR_BITS) != 20'd0) || w_req_map;
    assign w_lat_oor = ((r_addr >> ADDR_BITS) != 20'd0) || w_lat_map;
    assign w_io_src  = 16'h0000;
`endif

    // A write is taken only from IDLE, so WR_DONE guarantees one commit per access.
    assign w_cpu_wr  = (r_state == IDLE) && !CE && !WE;
    assign w_mem_wr  = w_cpu_wr && !w_req_oor && !w_req_io;
    assign w_init_wr = (r_state == IDLE) && Init_WE && !w_mem_wr;

    // Bus drive is gated live by the control pins so a write request (WE=0)
    // or deselect releases Data without waiting for a clock edge.
    assign w_drive  = (r_state == RD_DRIVE) && !CE && !OE && WE;
    assign Data     = w_drive ? r_rd_data : 16'hzzzz;
    assign Rd_Valid = w_drive;
    assign Err      = r_err;

    // Read word source with lane masking applied at capture time.
    always_comb begin
        w_rd_src = 16'h0000;
        if (w_lat_oor) begin
            w_rd_src = 16'h0000;
        end else if (w_lat_io) begin
            w_rd_src = w_io_src;
        end else begin
            w_rd_src = r_mem[r_addr[ADDR_BITS-1:0]];
        end
        w_rd_word = {(UB ? 8'h00 : w_rd_src[15:8]), (LB ? 8'h00 : w_rd_src[7:0])};
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_accept = 1'b0;
        w_capture   = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!CE && !WE) begin
                    w_state_nxt = WR_DONE;
                end else if (!CE && !OE) begin
                    w_state_nxt = RD_WAIT;
                    w_rd_accept = 1'b1;
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt != 2'd0) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                if (CE || OE || !WE) begin
                    w_state_nxt = IDLE;
                end else if (ADDR != r_addr) begin
                    w_state_nxt = RD_WAIT;
                    w_rd_accept = 1'b1;
                end
            end
            WR_DONE: begin
                if (CE || WE) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read address latch, latency counter, read data register and error pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_lat_cnt <= 2'd0;
            r_addr    <= 20'd0;
            r_rd_data <= 16'h0000;
            r_err     <= 1'b0;
        end else begin
            r_err <= (w_rd_accept || w_cpu_wr) && w_req_oor;
            if (w_rd_accept) begin
                r_addr    <= ADDR;
                r_lat_cnt <= c_LAT_INIT;
            end else if (w_cnt_dec) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (w_capture) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // Word array: no reset so contents survive Reset; writes are suppressed
    // while Reset is held so nothing commits during reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (w_mem_wr) begin
                if (!UB) begin
                    r_mem[ADDR[ADDR_BITS-1:0]][15:8] <= Data[15:8];
                end
                if (!LB) begin
                    r_mem[ADDR[ADDR_BITS-1:0]][7:0] <= Data[7:0];
                end
            end else if (w_init_wr) begin
                r_mem[Init_Addr] <= Init_Data;
            end
        end
    end

`ifdef SRAM_RESPONDER_IO_EN
    logic [15:0] r_hex;

    // Hex display register written through the I/O address, per byte lane.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hex <= 16'h0000;
        end else if (w_cpu_wr && w_req_io) begin
            if (!UB) begin
                r_hex[15:8] <= Data[15:8];
            end
            if (!LB) begin
                r_hex[7:0] <= Data[7:0];
            end
        end
    end

    assign Hex_Out = r_hex;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_responder
//  Description : Self-checking bench for sram_responder: directed vector
//                table, multi-cycle corner sequences (reset, dropped preload,
//                address change with READ_LATENCY=3) and randomized
//                transactions checked against a word-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_responder;

    localparam int RL  = 1;
    localparam int RL3 = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] ADDR;
    logic        Init_WE;
    logic [7:0]  Init_Addr;
    logic [15:0] Init_Data;
    logic        tb_drive;
    logic [15:0] tb_data;
    wire  [15:0] Data;
    wire  [15:0] Data3;
    logic        Rd_Valid, Rd_Valid3;
    logic        Err, Err3;
`ifdef SRAM_RESPONDER_IO_EN
    logic [15:0] Switches;
    logic [15:0] Hex_Out, Hex_Out3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_mem [256];

    assign Data  = tb_drive ? tb_data : 16'hzzzz;
    assign Data3 = tb_drive ? tb_data : 16'hzzzz;

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_BITS(8), .READ_LATENCY(RL)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .ADDR(ADDR), .Data(Data), .Init_WE(Init_WE), .Init_Addr(Init_Addr),
        .Init_Data(Init_Data),
`ifdef SRAM_RESPONDER_IO_EN
        .Switches(Switches), .Hex_Out(Hex_Out),
`endif
        .Rd_Valid(Rd_Valid), .Err(Err)
    );

    sram_responder #(.ADDR_BITS(8), .READ_LATENCY(RL3)) dut3 (
        .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .ADDR(ADDR), .Data(Data3), .Init_WE(Init_WE), .Init_Addr(Init_Addr),
        .Init_Data(Init_Data),
`ifdef SRAM_RESPONDER_IO_EN
        .Switches(Switches), .Hex_Out(Hex_Out3),
`endif
        .Rd_Valid(Rd_Valid3), .Err(Err3)
    );

    typedef struct {
        bit          is_wr;
        logic [19:0] addr;
        logic [15:0] data;
        bit          ub;
        bit          lb;
        bit          oe;
        int          hold;
        logic [15:0] exp;
        bit          exp_err;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lanes(input logic [15:0] w, input bit ub, input bit lb);
        return {(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])};
    endfunction

    task automatic init_wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clk);
        Init_WE = 1'b1; Init_Addr = a; Init_Data = d;
        @(negedge Clk);
        Init_WE = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic do_read(input logic [19:0] a, input bit ub, input bit lb, input int hold,
                           input logic [15:0] exp, input bit exp_err);
        @(negedge Clk);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = a; UB = ub; LB = lb;
        for (int k = 1; k <= RL + hold; k++) begin
            @(posedge Clk); #1;
            chk("rd_err", {31'd0, Err}, (k == 1) ? {31'd0, exp_err} : 32'd0);
            if (k <= RL) begin
                chk("rd_wait_valid", {31'd0, Rd_Valid}, 32'd0);
            end else begin
                chk("rd_valid", {31'd0, Rd_Valid}, 32'd1);
                chk("rd_data", {16'd0, Data}, {16'd0, exp});
            end
        end
        @(negedge Clk);
        CE = 1'b1; OE = 1'b1;
        #1 chk("rd_release", {31'd0, Rd_Valid}, 32'd0);
        @(posedge Clk);
    endtask

    // The bus value flips after the first edge so a second commit would show.
    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input bit ub,
                            input bit lb, input bit oe, input int hold, input bit exp_err);
        @(negedge Clk);
        CE = 1'b0; WE = 1'b0; OE = oe; ADDR = a; UB = ub; LB = lb;
        tb_data = d; tb_drive = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(posedge Clk); #1;
            chk("wr_no_drive", {31'd0, Rd_Valid}, 32'd0);
            chk("wr_err", {31'd0, Err}, (k == 1) ? {31'd0, exp_err} : 32'd0);
            tb_data = d ^ 16'hFFFF;
        end
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1; OE = 1'b1; tb_drive = 1'b0;
        @(posedge Clk);
    endtask

    initial begin
        Reset = 1'b0; CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
        ADDR = 20'd0; Init_WE = 1'b0; Init_Addr = 8'd0; Init_Data = 16'd0;
        tb_drive = 1'b0; tb_data = 16'd0;
`ifdef SRAM_RESPONDER_IO_EN
        Switches = 16'h00F3;
`endif
        // Reset state
        idle(3);
        chk("reset_rd_valid", {31'd0, Rd_Valid}, 32'd0);
        chk("reset_err", {31'd0, Err}, 32'd0);
        chk("reset_rd_valid3", {31'd0, Rd_Valid3}, 32'd0);
`ifdef SRAM_RESPONDER_IO_EN
        chk("reset_hex", {16'd0, Hex_Out}, 32'd0);
`endif
        Reset = 1'b1;
        idle(2);

        init_wr(8'h12, 16'hBEEF);
        init_wr(8'h05, 16'h1111);
        init_wr(8'h20, 16'hABCD);
        init_wr(8'h21, 16'h5555);
        init_wr(8'h07, 16'h0000);
        init_wr(8'h30, 16'h0000);

        //        wr    addr       data      ub    lb    oe    hold exp       err
        tbl[0]  = '{1'b0, 20'h00012, 16'h0000, 1'b0, 1'b0, 1'b0, 2, 16'hBEEF, 1'b0};
        tbl[1]  = '{1'b1, 20'h00005, 16'hA5C3, 1'b1, 1'b0, 1'b1, 3, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h11C3, 1'b0};
        tbl[3]  = '{1'b0, 20'h00005, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h00C3, 1'b0};
        tbl[4]  = '{1'b0, 20'h00012, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 16'hBE00, 1'b0};
        tbl[5]  = '{1'b1, 20'h00020, 16'h1234, 1'b0, 1'b1, 1'b1, 1, 16'h0000, 1'b0};
        tbl[6]  = '{1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h12CD, 1'b0};
        tbl[7]  = '{1'b1, 20'h00021, 16'hFFFF, 1'b1, 1'b1, 1'b1, 2, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 20'h00021, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h5555, 1'b0};
        tbl[9]  = '{1'b1, 20'h00007, 16'h0042, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 20'h00007, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h0042, 1'b0};
        tbl[11] = '{1'b0, 20'h10000, 16'h0000, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b1};
        tbl[12] = '{1'b1, 20'h10005, 16'h9999, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 1'b1};
        tbl[13] = '{1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h11C3, 1'b0};
`ifdef SRAM_RESPONDER_IO_EN
        tbl[14] = '{1'b0, 20'h0FFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h00F3, 1'b0};
        tbl[15] = '{1'b1, 20'h0FFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 1'b0};
`else
        tbl[14] = '{1'b0, 20'h0FFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h0000, 1'b1};
        tbl[15] = '{1'b1, 20'h0FFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 1'b1};
`endif
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_wr)
                do_write(tbl[i].addr, tbl[i].data, tbl[i].ub, tbl[i].lb, tbl[i].oe,
                         tbl[i].hold, tbl[i].exp_err);
            else
                do_read(tbl[i].addr, tbl[i].ub, tbl[i].lb, tbl[i].hold,
                        tbl[i].exp, tbl[i].exp_err);
        end
`ifdef SRAM_RESPONDER_IO_EN
        #1 chk("hex_out", {16'd0, Hex_Out}, 32'h0000_1234);
`endif

        // Preload arriving while a read is being driven is dropped
        @(negedge Clk);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00012; UB = 1'b0; LB = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        chk("drop_rd_valid", {31'd0, Rd_Valid}, 32'd1);
        @(negedge Clk);
        Init_WE = 1'b1; Init_Addr = 8'h12; Init_Data = 16'h0000;
        @(negedge Clk);
        Init_WE = 1'b0; CE = 1'b1; OE = 1'b1;
        do_read(20'h00012, 1'b0, 1'b0, 1, 16'hBEEF, 1'b0);

        // Reset in RD_DRIVE releases the bus before the next edge
        @(negedge Clk);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00012;
        @(posedge Clk); @(posedge Clk); #1;
        chk("rst_pre_valid", {31'd0, Rd_Valid}, 32'd1);
        #2 Reset = 1'b0;
        #1 chk("rst_async_valid", {31'd0, Rd_Valid}, 32'd0);
        chk("rst_async_err", {31'd0, Err}, 32'd0);
        @(negedge Clk);
        CE = 1'b1; OE = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        do_read(20'h00012, 1'b0, 1'b0, 1, 16'hBEEF, 1'b0);

        // Reset right after a write commit leaves the committed word intact
        @(negedge Clk);
        CE = 1'b0; WE = 1'b0; OE = 1'b1; ADDR = 20'h00030; UB = 1'b0; LB = 1'b0;
        tb_data = 16'h7777; tb_drive = 1'b1;
        @(posedge Clk); #2;
        Reset = 1'b0; tb_data = 16'h0F0F;
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1; tb_drive = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        do_read(20'h00030, 1'b0, 1'b0, 1, 16'h7777, 1'b0);

        // Randomized transactions against the word-array model
        for (int a = 0; a < 256; a++) begin
            model_mem[a] = 16'($urandom);
            init_wr(8'(a), model_mem[a]);
        end
        for (int t = 0; t < 60; t++) begin
            int          kind;
            bit          oor, ub, lb;
            logic [7:0]  low;
            logic [19:0] a;
            logic [15:0] d;
            kind = int'($urandom_range(0, 9));
            oor  = ($urandom_range(0, 7) == 0);
            low  = 8'($urandom_range(0, 255));
            a    = oor ? {4'($urandom_range(1, 15)), 8'h00, low} : {12'h000, low};
            ub   = 1'($urandom_range(0, 1));
            lb   = 1'($urandom_range(0, 1));
            d    = 16'($urandom);
            if (kind <= 4) begin
                do_read(a, ub, lb, int'($urandom_range(1, 3)),
                        oor ? 16'h0000 : lanes(model_mem[low], ub, lb), oor);
            end else if (kind <= 8) begin
                do_write(a, d, ub, lb, 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, 3)), oor);
                if (!oor) begin
                    if (!ub) model_mem[low][15:8] = d[15:8];
                    if (!lb) model_mem[low][7:0]  = d[7:0];
                end
            end else begin
                model_mem[low] = d;
                init_wr(low, d);
            end
        end
        for (int a = 0; a < 8; a++) begin
            do_read({12'h000, 8'(a * 37)}, 1'b0, 1'b0, 1, model_mem[8'(a * 37)], 1'b0);
        end

        // READ_LATENCY=3: address change in RD_DRIVE re-enters the wait
        idle(6);
        init_wr(8'h01, 16'h0101);
        init_wr(8'h02, 16'h0202);
        @(negedge Clk);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00001; UB = 1'b0; LB = 1'b0;
        for (int k = 1; k <= RL3 + 1; k++) begin
            @(posedge Clk); #1;
            if (k <= RL3) begin
                chk("rl3_wait_valid", {31'd0, Rd_Valid3}, 32'd0);
            end else begin
                chk("rl3_valid", {31'd0, Rd_Valid3}, 32'd1);
                chk("rl3_data", {16'd0, Data3}, 32'h0000_0101);
            end
        end
        @(negedge Clk);
        ADDR = 20'h00002;
        for (int k = 1; k <= RL3 + 1; k++) begin
            @(posedge Clk); #1;
            if (k <= RL3) begin
                chk("rl3_rewait_valid", {31'd0, Rd_Valid3}, 32'd0);
            end else begin
                chk("rl3_revalid", {31'd0, Rd_Valid3}, 32'd1);
                chk("rl3_redata", {16'd0, Data3}, 32'h0000_0202);
            end
        end
        @(negedge Clk);
        CE = 1'b1; OE = 1'b1;
        #1 chk("rl3_release", {31'd0, Rd_Valid3}, 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
